md_unit: RTL and testbench

- Parametrised multiply/divide unit with HI/LO registers for the pipelined MIPS core; successor to the single-cycle ALU control path.
- Decodes the R-type func field for mult/multu/div/divu/mthi/mtlo and runs multi-cycle operations under a busy counter.
- Sits in the EX stage beside the ALU.
- The hazard unit stalls on start|busy; mfhi/mflo read the hi/lo outputs directly.

---
 rtl/md_unit.sv | 114 +++++++++++
 tb/tb_md_unit.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO registers for the EX stage.
// Results are computed at accept time and committed to HI/LO after a fixed busy countdown.
module md_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             md_en,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             start,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] MULT_CNT = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_CNT  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  localparam logic [WIDTH-1:0] W_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic [WIDTH-1:0]   pend_hi_q, pend_lo_q;
  logic [WIDTH-1:0]   res_hi_d, res_lo_d;

  logic               is_mul_s, is_mul_u, is_div_s, is_div_u, is_div, md_op;
  logic [2*WIDTH-1:0] op_a_ext, op_b_ext, prod;
  logic               sgn_a, sgn_b;
  logic [WIDTH-1:0]   mag_a, mag_b, den, uq, ur, sq, sr;

  assign is_mul_s = (func == F_MULT);
  assign is_mul_u = (func == F_MULTU);
  assign is_div_s = (func == F_DIV);
  assign is_div_u = (func == F_DIVU);
  assign is_div   = is_div_s | is_div_u;
  assign md_op    = is_mul_s | is_mul_u | is_div;

  assign busy  = (cnt_q != '0);
  assign start = md_en & ~busy & md_op;
  assign hi    = hi_q;
  assign lo    = lo_q;

  // Truncated 2W-bit product of extended operands equals the exact signed/unsigned product.
  assign op_a_ext = is_mul_s ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
  assign op_b_ext = is_mul_s ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
  assign prod     = op_a_ext * op_b_ext;

  // Signed divide via magnitudes; the -2^(W-1)/-1 case falls out as lo=-2^(W-1), hi=0.
  assign sgn_a = is_div_s & a[WIDTH-1];
  assign sgn_b = is_div_s & b[WIDTH-1];
  assign mag_a = sgn_a ? (~a + W_ONE) : a;
  assign mag_b = sgn_b ? (~b + W_ONE) : b;
  assign den   = (b == '0) ? W_ONE : mag_b;
  assign uq    = mag_a / den;
  assign ur    = mag_a % den;
  assign sq    = (sgn_a ^ sgn_b) ? (~uq + W_ONE) : uq;
  assign sr    = sgn_a ? (~ur + W_ONE) : ur;

  always_comb begin
    res_hi_d = prod[2*WIDTH-1:WIDTH];
    res_lo_d = prod[WIDTH-1:0];
    cnt_d    = MULT_CNT;
    if (is_div) begin
      cnt_d = DIV_CNT;
      if (b == '0) begin
        res_hi_d = a;
        res_lo_d = '1;
      end else begin
        res_hi_d = sr;
        res_lo_d = sq;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
    end else if (busy) begin
      cnt_q <= cnt_q - CNT_ONE;
      if (cnt_q == CNT_ONE) begin
        hi_q <= pend_hi_q;
        lo_q <= pend_lo_q;
      end
    end else if (start) begin
      cnt_q     <= cnt_d;
      pend_hi_q <= res_hi_d;
      pend_lo_q <= res_lo_d;
    end else if (md_en && func == F_MTHI) begin
      hi_q <= a;
    end else if (md_en && func == F_MTLO) begin
      lo_q <= a;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases, randomized ops against a behavioural model,
// and a second instance with MULT_CYCLES=1 / DIV_CYCLES=33.
module tb_md_unit;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_ADD   = 6'b100000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        md_en = 1'b0;
  logic [5:0]  func = '0;
  logic [31:0] a = '0, b = '0;
  logic        start, busy, start2, busy2;
  logic [31:0] hi, lo, hi2, lo2;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] m_hi, m_lo;

  always #5 clk = ~clk;

  md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .md_en(md_en), .func(func), .a(a), .b(b),
    .start(start), .busy(busy), .hi(hi), .lo(lo));

  md_unit #(.WIDTH(32), .MULT_CYCLES(1), .DIV_CYCLES(33)) dut2 (
    .clk(clk), .reset(reset), .md_en(md_en), .func(func), .a(a), .b(b),
    .start(start2), .busy(busy2), .hi(hi2), .lo(lo2));

  // Reference result {hi, lo} from the architectural definition of each op.
  function automatic logic [63:0] ref_md(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
    longint          ps;
    longint unsigned pu;
    int              q, r;
    case (f)
      F_MULT: begin
        ps = longint'($signed(x)) * longint'($signed(y));
        return ps;
      end
      F_MULTU: begin
        pu = {32'b0, x} * {32'b0, y};
        return pu;
      end
      F_DIV: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = $signed(x) / $signed(y);
        r = $signed(x) % $signed(y);
        return {r, q};
      end
      default: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  task automatic apply_reset();
    md_en = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    m_hi = '0;
    m_lo = '0;
  endtask

  // Presents one op at a negedge and measures busy width on the selected instance.
  task automatic run_op(input bit sel, input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                        output logic st, output int width, output logic [31:0] h, output logic [31:0] l);
    md_en = 1'b1; func = f; a = x; b = y;
    #1;
    st = sel ? start2 : start;
    @(negedge clk);
    md_en = 1'b0;
    width = 0;
    while ((sel ? busy2 : busy) && width < 400) begin
      width++;
      @(negedge clk);
    end
    h = sel ? hi2 : hi;
    l = sel ? lo2 : lo;
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_state: busy=%b hi=%h lo=%h, want busy=0 hi=0 lo=0", busy, hi, lo);
    end
    func = F_MULT; md_en = 1'b0; #1;
    vectors++;
    if (start !== 1'b0) begin
      miscompares++;
      $display("FAIL start_no_en: start=%b want 0", start);
    end
    md_en = 1'b1; #1;
    vectors++;
    if (start !== 1'b1) begin
      miscompares++;
      $display("FAIL start_idle: start=%b want 1", start);
    end
    md_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [5:0]  fs [6] = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_DIV, F_DIV};
    logic [31:0] xs [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'h7, 32'h1234, 32'h8000_0000};
    logic [31:0] ys [6] = '{32'h2, 32'h2, 32'h2, 32'h2, 32'h0, 32'hFFFF_FFFF};
    logic [31:0] eh [6] = '{32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFF, 32'h1, 32'h1234, 32'h0};
    logic [31:0] el [6] = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h3, 32'hFFFF_FFFF, 32'h8000_0000};
    int          ew [6] = '{5, 5, 10, 10, 10, 10};
    logic st;
    int w;
    logic [31:0] h, l;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      run_op(1'b0, fs[i], xs[i], ys[i], st, w, h, l);
      vectors++;
      if (st !== 1'b1 || w != ew[i] || h !== eh[i] || l !== el[i]) begin
        miscompares++;
        $display("FAIL directed_%0d: start=%b busy=%0d hi=%h lo=%h, want start=1 busy=%0d hi=%h lo=%h",
                 i, st, w, h, l, ew[i], eh[i], el[i]);
      end
    end
  endtask

  task automatic test_busy_ignore();
    apply_reset();
    md_en = 1'b1; func = F_MULT; a = 32'd3; b = 32'd4;
    @(negedge clk);
    md_en = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      vectors++;
      if (busy !== 1'b1) begin
        miscompares++;
        $display("FAIL busy_cycle_%0d: busy=%b want 1", c, busy);
      end
      if (c >= 2) begin
        md_en = 1'b1;
        func = (c % 2 == 0) ? F_DIVU : F_MTHI;
        a = (c % 2 == 0) ? 32'd9 : 32'h55;
        b = 32'd2;
        #1;
        vectors++;
        if (start !== 1'b0) begin
          miscompares++;
          $display("FAIL start_while_busy_%0d: start=%b want 0", c, start);
        end
      end
      @(negedge clk);
    end
    md_en = 1'b0;
    vectors++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'hC) begin
      miscompares++;
      $display("FAIL ignore_result: busy=%b hi=%h lo=%h, want busy=0 hi=0 lo=0000000c", busy, hi, lo);
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL ignore_no_accept: busy=%b want 0", busy);
    end
    md_en = 1'b1; func = F_MTHI; a = 32'h55;
    @(negedge clk);
    md_en = 1'b0;
    vectors++;
    if (hi !== 32'h55 || lo !== 32'hC) begin
      miscompares++;
      $display("FAIL mthi_idle: hi=%h lo=%h, want hi=00000055 lo=0000000c", hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    int w;
    apply_reset();
    md_en = 1'b1; func = F_MULT; a = 32'd6; b = 32'd7;
    @(negedge clk);
    func = F_DIVU; a = 32'd100; b = 32'd7;
    w = 0;
    while (busy && w < 400) begin
      w++;
      @(negedge clk);
    end
    vectors++;
    if (w != 5 || start !== 1'b1 || hi !== 32'h0 || lo !== 32'd42) begin
      miscompares++;
      $display("FAIL b2b_first: busy=%0d start=%b hi=%h lo=%h, want busy=5 start=1 hi=0 lo=0000002a",
               w, start, hi, lo);
    end
    @(negedge clk);
    md_en = 1'b0;
    w = 0;
    while (busy && w < 400) begin
      w++;
      @(negedge clk);
    end
    vectors++;
    if (w != 10 || hi !== 32'd2 || lo !== 32'd14) begin
      miscompares++;
      $display("FAIL b2b_second: busy=%0d hi=%h lo=%h, want busy=10 hi=2 lo=0000000e", w, hi, lo);
    end
  endtask

  task automatic test_reset_abort();
    apply_reset();
    md_en = 1'b1; func = F_MTHI; a = 32'hAAAA;
    @(negedge clk);
    func = F_MTLO; a = 32'hBBBB;
    @(negedge clk);
    func = F_DIV; a = 32'd100; b = 32'd7;
    @(negedge clk);
    md_en = 1'b0;
    for (int c = 1; c < 4; c++) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    vectors++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      miscompares++;
      $display("FAIL abort_reset: busy=%b hi=%h lo=%h, want busy=0 hi=0 lo=0", busy, hi, lo);
    end
    for (int c = 0; c < 15; c++) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      miscompares++;
      $display("FAIL abort_no_commit: busy=%b hi=%h lo=%h, want busy=0 hi=0 lo=0", busy, hi, lo);
    end
  endtask

  task automatic test_random();
    logic [5:0] fl [7] = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO, F_ADD};
    logic [5:0] f;
    logic [31:0] x, y, h, l;
    logic [63:0] r;
    logic st;
    int w, ew;
    apply_reset();
    for (int i = 0; i < 40; i++) begin
      f = fl[$urandom_range(0, 6)];
      x = $urandom;
      case ($urandom_range(0, 7))
        0: y = '0;
        1: y = 32'(1 + $urandom_range(0, 20));
        2: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        default: y = $urandom;
      endcase
      if (f == F_MTHI || f == F_MTLO || f == F_ADD) begin
        md_en = 1'b1; func = f; a = x; b = y;
        #1;
        st = start;
        @(negedge clk);
        md_en = 1'b0;
        if (f == F_MTHI) m_hi = x;
        if (f == F_MTLO) m_lo = x;
        vectors++;
        if (st !== 1'b0 || busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
          miscompares++;
          $display("FAIL rand_move_%0d: func=%b start=%b busy=%b hi=%h lo=%h, want 0 0 hi=%h lo=%h",
                   i, f, st, busy, hi, lo, m_hi, m_lo);
        end
      end else begin
        run_op(1'b0, f, x, y, st, w, h, l);
        r = ref_md(f, x, y);
        m_hi = r[63:32];
        m_lo = r[31:0];
        ew = (f == F_DIV || f == F_DIVU) ? 10 : 5;
        vectors++;
        if (st !== 1'b1 || w != ew || h !== m_hi || l !== m_lo) begin
          miscompares++;
          $display("FAIL rand_op_%0d: func=%b a=%h b=%h start=%b busy=%0d hi=%h lo=%h, want 1 %0d hi=%h lo=%h",
                   i, f, x, y, st, w, h, l, ew, m_hi, m_lo);
        end
      end
    end
  endtask

  task automatic test_sweep();
    logic [5:0] fl [4] = '{F_MULT, F_DIV, F_MULTU, F_DIVU};
    logic [31:0] x, y, h, l;
    logic [63:0] r;
    logic st;
    int w, ew;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      x = $urandom;
      y = (i == 3) ? 32'h0 : $urandom;
      run_op(1'b1, fl[i % 4], x, y, st, w, h, l);
      r = ref_md(fl[i % 4], x, y);
      ew = (fl[i % 4] == F_DIV || fl[i % 4] == F_DIVU) ? 33 : 1;
      vectors++;
      if (st !== 1'b1 || w != ew || h !== r[63:32] || l !== r[31:0]) begin
        miscompares++;
        $display("FAIL sweep_%0d: start=%b busy=%0d hi=%h lo=%h, want 1 %0d hi=%h lo=%h",
                 i, st, w, h, l, ew, r[63:32], r[31:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_busy_ignore();
    test_back_to_back();
    test_reset_abort();
    test_random();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
